// File: rtl/us_burst_sequencer.sv
// Ultrasonic front-end sequencer: DAC level ramp plus TX -> guard -> RX timing.
// Ports: clk/rst, cmd_* host command strobe and fields, cmd_ready, enabled,
//   dac_code/dac_wr DAC drive, tx_en/rx_en switch pins, cycle_done, err_cmd.
module us_burst_sequencer #(
  parameter int AMOUNT_WIDTH = 8,
  parameter int CNT_W        = 16,
  parameter int TX_CYCLES    = 200,
  parameter int GUARD_CYCLES = 50,
  parameter int RX_CYCLES    = 4000,
  parameter int RAMP_DIV     = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  input  logic                    cmd_on,
  input  logic                    cmd_off,
  input  logic                    cmd_inc,
  input  logic                    cmd_dec,
  input  logic                    cmd_send,
  input  logic                    cmd_receive,
  input  logic [AMOUNT_WIDTH-1:0] cmd_amount,
  output logic                    cmd_ready,
  output logic                    enabled,
  output logic [AMOUNT_WIDTH-1:0] dac_code,
  output logic                    dac_wr,
  output logic                    tx_en,
  output logic                    rx_en,
  output logic                    cycle_done,
  output logic                    err_cmd
);

  typedef enum logic [1:0] {
    IDLE, TX, GUARD, RX
  } state_t;

  localparam int AW = AMOUNT_WIDTH;
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_CYCLES - 1);
  localparam logic [CNT_W-1:0] GD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AW-1:0]    LSB     = AW'(1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  pre;
  logic              rx_flag, rx_flag_nxt;
  logic [AW-1:0]     target, target_nxt;
  logic              enabled_nxt;
  logic              done_nxt, err_nxt;
  logic              on_ok, off_ok, inc_ok, dec_ok, req, pair_err;
  logic [AW:0]       sum;

  // Conflicting pairs are dropped as a pair; the rest of the command stands.
  assign on_ok    = cmd_valid & cmd_on & ~cmd_off;
  assign off_ok   = cmd_valid & cmd_off & ~cmd_on;
  assign inc_ok   = cmd_valid & cmd_inc & ~cmd_dec;
  assign dec_ok   = cmd_valid & cmd_dec & ~cmd_inc;
  assign req      = cmd_valid & (cmd_send | cmd_receive);
  assign pair_err = cmd_valid &
                    ((cmd_on & cmd_off) | (cmd_inc & cmd_dec));
  assign sum      = {1'b0, target} + {1'b0, cmd_amount};

  assign cmd_ready = (state == IDLE);
  assign tx_en     = (state == TX);
  assign rx_en     = (state == RX);

  always_comb begin
    target_nxt  = target;
    enabled_nxt = enabled;
    if (inc_ok)
      target_nxt = sum[AW] ? '1 : sum[AW-1:0];
    else if (dec_ok)
      target_nxt = (cmd_amount > target) ? '0 : target - cmd_amount;
    if (on_ok)
      enabled_nxt = 1'b1;
    if (off_ok) begin
      enabled_nxt = 1'b0;
      target_nxt  = '0;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rx_flag_nxt = rx_flag;
    done_nxt    = 1'b0;
    err_nxt     = pair_err;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (enabled && !off_ok) begin
            cnt_nxt     = '0;
            rx_flag_nxt = cmd_receive;
            state_nxt   = cmd_send ? TX : RX;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      TX: begin
        if (req) err_nxt = 1'b1;
        if (cnt == TX_LAST) begin
          cnt_nxt   = '0;
          state_nxt = GUARD;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      GUARD: begin
        if (req) err_nxt = 1'b1;
        if (cnt == GD_LAST) begin
          cnt_nxt = '0;
          if (rx_flag) begin
            state_nxt = RX;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      RX: begin
        if (req) err_nxt = 1'b1;
        if (cnt == RX_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over normal progress and never reports completion.
    if (off_ok) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      rx_flag_nxt = 1'b0;
      done_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rx_flag    <= 1'b0;
      target     <= '0;
      enabled    <= 1'b0;
      cycle_done <= 1'b0;
      err_cmd    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      rx_flag    <= rx_flag_nxt;
      target     <= target_nxt;
      enabled    <= enabled_nxt;
      cycle_done <= done_nxt;
      err_cmd    <= err_nxt;
    end
  end

  // Prescaler free-runs only while off target, so retargeting keeps phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre      <= '0;
      dac_code <= '0;
      dac_wr   <= 1'b0;
    end else begin
      dac_wr <= 1'b0;
      if (dac_code != target) begin
        if (pre == RP_LAST) begin
          pre    <= '0;
          dac_wr <= 1'b1;
          if (target > dac_code)
            dac_code <= dac_code + LSB;
          else
            dac_code <= dac_code - LSB;
        end else begin
          pre <= pre + CNT_ONE;
        end
      end else begin
        pre <= '0;
      end
    end
  end

endmodule

// File: tb/tb_us_burst_sequencer.sv
// Testbench for us_burst_sequencer: table vectors, corner-case sequences,
// and random commands checked against a queue-based schedule model.
module tb_us_burst_sequencer;

  localparam int AW  = 8;
  localparam int TXC = 5;
  localparam int GC  = 2;
  localparam int RXC = 8;
  localparam int RD  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_on, cmd_off, cmd_inc, cmd_dec;
  logic          cmd_send, cmd_receive;
  logic [AW-1:0] cmd_amount;
  logic          cmd_ready, enabled, dac_wr, tx_en, rx_en;
  logic          cycle_done, err_cmd;
  logic [AW-1:0] dac_code;

  us_burst_sequencer #(
    .AMOUNT_WIDTH(AW), .CNT_W(16), .TX_CYCLES(TXC),
    .GUARD_CYCLES(GC), .RX_CYCLES(RXC), .RAMP_DIV(RD)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_on(cmd_on),
    .cmd_off(cmd_off), .cmd_inc(cmd_inc), .cmd_dec(cmd_dec),
    .cmd_send(cmd_send), .cmd_receive(cmd_receive),
    .cmd_amount(cmd_amount), .cmd_ready(cmd_ready), .enabled(enabled),
    .dac_code(dac_code), .dac_wr(dac_wr), .tx_en(tx_en), .rx_en(rx_en),
    .cycle_done(cycle_done), .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: schedule queue of busy cycles (1=TX, 2=RX, 3=guard).
  bit m_en, m_wr, m_done, m_err;
  int m_tgt, m_dac, m_mis;
  int q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_wr = 0; m_done = 0; m_err = 0;
    m_tgt = 0; m_dac = 0; m_mis = 0;
    q.delete();
  endtask

  task automatic check_all();
    bit etx, erx;
    etx = (q.size() > 0) && (q[0] == 1);
    erx = (q.size() > 0) && (q[0] == 2);
    chk("enabled", enabled, m_en);
    chk("dac_code", dac_code, m_dac);
    chk("dac_wr", dac_wr, m_wr);
    chk("tx_en", tx_en, etx);
    chk("rx_en", rx_en, erx);
    chk("cmd_ready", cmd_ready, q.size() == 0);
    chk("cycle_done", cycle_done, m_done);
    chk("err_cmd", err_cmd, m_err);
  endtask

  task automatic model_step(bit v, bit on, bit off, bit inc, bit dec,
                            bit snd, bit rcv, int amt);
    bit busy, en_pre;
    busy   = q.size() > 0;
    en_pre = m_en;
    m_wr = 0;
    if (m_dac != m_tgt) begin
      m_mis++;
      if (m_mis == RD) begin
        m_mis = 0;
        m_dac = m_dac + ((m_tgt > m_dac) ? 1 : -1);
        m_wr = 1;
      end
    end else begin
      m_mis = 0;
    end
    m_done = 0;
    if (busy) begin
      void'(q.pop_front());
      if (q.size() == 0) m_done = 1;
    end
    m_err = 0;
    if (v) begin
      if (on && off) m_err = 1;
      if (inc && dec) m_err = 1;
      if (inc && !dec) m_tgt = (m_tgt + amt > 255) ? 255 : m_tgt + amt;
      if (dec && !inc) m_tgt = (m_tgt - amt < 0) ? 0 : m_tgt - amt;
      if (on && !off) m_en = 1;
      if (off && !on) begin
        m_en = 0; m_tgt = 0; m_done = 0;
        q.delete();
      end
      if (snd || rcv) begin
        if (busy || !en_pre || (off && !on)) begin
          m_err = 1;
        end else begin
          if (snd) begin
            repeat (TXC) q.push_back(1);
            repeat (GC) q.push_back(3);
          end
          if (rcv) repeat (RXC) q.push_back(2);
        end
      end
    end
  endtask

  task automatic cyc(bit v, bit on, bit off, bit inc, bit dec,
                     bit snd, bit rcv, int amt);
    cmd_valid = v; cmd_on = on; cmd_off = off; cmd_inc = inc;
    cmd_dec = dec; cmd_send = snd; cmd_receive = rcv;
    cmd_amount = AW'(amt);
    model_step(v, on, off, inc, dec, snd, rcv, amt);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_dac(int val, int budget);
    int k;
    k = 0;
    while (dac_code !== AW'(val) && k < budget) begin
      idle(1);
      k++;
    end
    chk("wait_dac", dac_code, val);
  endtask

  task automatic do_reset();
    cmd_valid = 0; cmd_on = 0; cmd_off = 0; cmd_inc = 0; cmd_dec = 0;
    cmd_send = 0; cmd_receive = 0; cmd_amount = '0;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 0;
  endtask

  typedef struct {
    bit v, on, off, inc, dec, snd, rcv;
    int amt;
    bit en, err, rdy, tx, rx;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int n_tx, n_rx, n_done, n_both, last_tx, first_rx, first_wr, prev_wr;
    int n_wr, bad_gap;

    //           v on of in de sn rc amt  en er rd tx rx
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0};
    tbl[3]  = '{1, 1, 1, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 1, 1, 0, 0, 3,   1, 1, 1, 0, 0};
    tbl[5]  = '{1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 1, 0,   1, 1, 1, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1};
    tbl[8]  = '{1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0};
    tbl[9]  = '{1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 0};
    tbl[11] = '{1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0};

    do_reset();
    chk("rst_dac", dac_code, 0);
    chk("rst_tx", tx_en, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].v, tbl[i].on, tbl[i].off, tbl[i].inc, tbl[i].dec,
          tbl[i].snd, tbl[i].rcv, tbl[i].amt);
      chk($sformatf("tbl%0d_en", i), enabled, tbl[i].en);
      chk($sformatf("tbl%0d_err", i), err_cmd, tbl[i].err);
      chk($sformatf("tbl%0d_rdy", i), cmd_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_tx", i), tx_en, tbl[i].tx);
      chk($sformatf("tbl%0d_rx", i), rx_en, tbl[i].rx);
      chk($sformatf("tbl%0d_dac", i), dac_code, 0);
    end

    // Ramp 0 -> 10 at one LSB every RD cycles.
    do_reset();
    cyc(1, 1, 0, 1, 0, 0, 0, 10);
    n_wr = 0; first_wr = -1; prev_wr = 0; bad_gap = 0;
    for (int k = 1; k <= 60; k++) begin
      idle(1);
      if (dac_wr) begin
        if (first_wr < 0) first_wr = k;
        else if (k - prev_wr != RD) bad_gap++;
        prev_wr = k;
        n_wr++;
      end
    end
    chk("ramp_pulses", n_wr, 10);
    chk("ramp_first", first_wr, RD);
    chk("ramp_spacing", bad_gap, 0);
    chk("ramp_final", dac_code, 10);

    // Saturation at the top and floor at zero.
    cyc(1, 0, 0, 1, 0, 0, 0, 240);
    wait_dac(250, 1200);
    cyc(1, 0, 0, 1, 0, 0, 0, 20);
    wait_dac(255, 200);
    idle(3 * RD);
    chk("sat_hold", dac_code, 255);
    cyc(1, 0, 0, 0, 1, 0, 0, 250);
    wait_dac(5, 1200);
    cyc(1, 0, 0, 0, 1, 0, 0, 255);
    wait_dac(0, 200);
    idle(3 * RD);
    chk("floor_hold", dac_code, 0);

    // Full send+receive sequence timing.
    cyc(1, 0, 0, 0, 0, 1, 1, 0);
    n_tx = 0; n_rx = 0; n_done = 0; n_both = 0;
    last_tx = -1; first_rx = -1;
    for (int k = 0; k < 25; k++) begin
      if (k > 0) idle(1);
      if (tx_en) begin n_tx++; last_tx = k; end
      if (rx_en) begin n_rx++; if (first_rx < 0) first_rx = k; end
      if (cycle_done) n_done++;
      if (tx_en && rx_en) n_both++;
    end
    chk("seq_tx_len", n_tx, TXC);
    chk("seq_rx_len", n_rx, RXC);
    chk("seq_gap", first_rx - last_tx - 1, GC);
    chk("seq_done", n_done, 1);
    chk("seq_overlap", n_both, 0);

    // Rejected send while disabled; send during RX is ignored.
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    chk("dis_send_err", err_cmd, 1);
    chk("dis_send_tx", tx_en, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    n_rx = 1;
    idle(2);
    n_rx += 2;
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    chk("rx_send_err", err_cmd, 1);
    n_rx += rx_en;
    for (int k = 0; k < 12; k++) begin
      idle(1);
      n_rx += rx_en;
    end
    chk("rx_len_kept", n_rx, RXC);

    // Abort during TX cycle 3 with a nonzero level.
    cyc(1, 0, 0, 1, 0, 0, 0, 6);
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    chk("abort_pre_tx", tx_en, 1);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    chk("abort_tx", tx_en, 0);
    chk("abort_ready", cmd_ready, 1);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      idle(1);
      n_done += cycle_done;
    end
    chk("abort_no_done", n_done, 0);
    wait_dac(0, 100);

    // on+off conflict with an inc alongside; then async reset in RX.
    cyc(1, 1, 1, 1, 0, 0, 0, 5);
    chk("conf_err", err_cmd, 1);
    chk("conf_en", enabled, 0);
    wait_dac(5, 100);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    chk("pre_rst_rx", rx_en, 1);
    #2 rst = 1;
    #1;
    chk("async_rx", rx_en, 0);
    chk("async_dac", dac_code, 0);
    chk("async_en", enabled, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    check_all();

    // Random command traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      bit v, on, off, inc, dec, snd, rcv;
      int amt;
      v   = ($urandom_range(0, 4) == 0);
      on  = ($urandom_range(0, 2) == 0);
      off = ($urandom_range(0, 9) == 0);
      inc = ($urandom_range(0, 2) == 0);
      dec = ($urandom_range(0, 3) == 0);
      snd = ($urandom_range(0, 3) == 0);
      rcv = ($urandom_range(0, 3) == 0);
      amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                         : $urandom_range(0, 6);
      cyc(v, on, off, inc, dec, snd, rcv, amt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
